serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/A_block.sv | 16 +
 rtl/serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the bit-index width helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-index width, clog2(width); never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder; the requester uses master,
// the adder uses slave.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, abort, op_a, op_b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, abort, op_a, op_b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/A_block.sv
// One-bit adder cell: sum bit plus generate/propagate terms. The carry chain
// is formed by the instantiating logic.
module A_block (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic g_o,
  output logic p_o
);

  assign s_o = a_i ^ b_i ^ cin_i;
  assign g_o = a_i & b_i;
  assign p_o = a_i | b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one operand bit per RUN cycle, LSB first,
// publishing sum/cout/ovf with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned IdxW = idx_width(WIDTH);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic              c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic              bit_s, bit_g, bit_p, carry_nxt, last_bit;

  A_block u_bit (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (c_q),
    .s_o   (bit_s),
    .g_o   (bit_g),
    .p_o   (bit_p)
  );

  assign carry_nxt = bit_g | (bit_p & c_q);
  assign last_bit  = (idx_q == IdxW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = bus.start ? StRun : StIdle;
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (last_bit) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operands shift right so the active bit is always at index 0; the result
  // fills from the top so it is LSB-aligned after WIDTH shifts.
  always_comb begin
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    res_d  = res_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (state_q != StRun) begin
      if (bus.start) begin
        a_d   = bus.op_a;
        b_d   = bus.op_b;
        c_d   = bus.cin;
        idx_d = '0;
        res_d = '0;
      end
    end else if (!bus.abort) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = carry_nxt;
      idx_d = idx_q + IdxW'(1);
      res_d = {bit_s, res_q[WIDTH-1:1]};
      if (last_bit) begin
        sum_d  = {bit_s, res_q[WIDTH-1:1]};
        cout_d = carry_nxt;
        ovf_d  = c_q ^ carry_nxt;
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: arithmetic reference model with per-cycle
// compare, plus directed scenarios with literal expectations.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: remaining RUN cycles plus the arithmetic result
  // computed directly from the operands when a start is accepted.
  int           m_cnt  = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  bit           m_cout = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] p_sum;
  bit           p_cout, p_ovf;
  longint       tot, sres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_cnt > 0) begin
      if (bus.abort) begin
        m_cnt = 0;
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
          m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        tot    = longint'(bus.op_a) + longint'(bus.op_b) + longint'(bus.cin);
        p_sum  = tot[W-1:0];
        p_cout = tot[W];
        sres   = longint'($signed(bus.op_a)) + longint'($signed(bus.op_b))
                 + longint'(bus.cin);
        p_ovf  = (sres > (longint'(1) << (W - 1)) - 1) || (sres < -(longint'(1) << (W - 1)));
        m_cnt  = W;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp busy", {31'b0, bus.busy}, {31'b0, m_cnt > 0});
    check("cmp done", {31'b0, bus.done}, {31'b0, m_done});
    check("cmp sum", 32'(bus.sum), 32'(m_sum));
    check("cmp cout", {31'b0, bus.cout}, {31'b0, m_cout});
    check("cmp ovf", {31'b0, bus.ovf}, {31'b0, m_ovf});
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic no_done(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {31'b0, bus.done}, 32'd0);
    end
  endtask

  task automatic check_res(input string name, input logic [W-1:0] s, input logic co,
                           input logic ov);
    check({name, " sum"}, 32'(bus.sum), 32'(s));
    check({name, " cout"}, {31'b0, bus.cout}, {31'b0, co});
    check({name, " ovf"}, {31'b0, bus.ovf}, {31'b0, ov});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;

    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check_res("reset", 8'h00, 1'b0, 1'b0);

    // 0x5A + 0x3C, start accepted on the first edge out of reset
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.op_a  = 8'h5A;
    bus.op_b  = 8'h3C;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("s1 busy after start", {31'b0, bus.busy}, 32'd1);
    wait_done("s1 done", 20, cyc);
    check("s1 latency", cyc, W);
    check_res("s1", 8'h96, 1'b0, 1'b1);
    check("model pin sum", 32'(m_sum), 32'h96);

    // 0xFF + 0x01, then 0xFF + 0x00 + 1 issued in DONE
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("s2a done", 20, cyc);
    check("s2a latency", cyc, W);
    check_res("s2a", 8'h00, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.op_a  = 8'hFF;
    bus.op_b  = 8'h00;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("s2 no idle gap", {31'b0, bus.busy}, 32'd1);
    wait_done("s2b done", 20, cyc);
    check("s2 done spacing", cyc + 1, W + 1);
    check_res("s2b", 8'h00, 1'b1, 1'b0);

    // 0x7F + 0x01 with a stray start mid-RUN
    start_op(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'h11;
    bus.op_b  = 8'h22;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("s3 done", 20, cyc);
    check("s3 latency", cyc + 4, W);
    check_res("s3", 8'h80, 1'b0, 1'b1);

    // Publish 0x96, then abort 0x10+0x20 in its 4th RUN cycle (start also high)
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done("s4 setup done", 20, cyc);
    check_res("s4 setup", 8'h96, 1'b0, 1'b1);
    start_op(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("s4 busy after abort", {31'b0, bus.busy}, 32'd0);
    no_done("s4 no done", 12);
    check_res("s4 held", 8'h96, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN
    start_op(8'h33, 8'h44, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5 async busy", {31'b0, bus.busy}, 32'd0);
    check("s5 async done", {31'b0, bus.done}, 32'd0);
    check_res("s5 async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("s5 no done", 12);
    // abort held while idle must not block acceptance
    bus.abort = 1'b1;
    start_op(8'h01, 8'h01, 1'b0);
    bus.abort = 1'b0;
    wait_done("s5 done", 20, cyc);
    check("s5 latency", cyc, W);
    check_res("s5", 8'h02, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
